calendar_date_counter: RTL and testbench

Parametrised day/month/year/weekday counter that replaces the per-field day counter in the clock datapath. It is advanced by the one-cycle day tick from the hour counter. Any one field can be adjusted up or down from the front-panel controls, with the day clamped to month length. It flags a one-cycle carry when the year range wraps, for the century/era stage.

---
 rtl/calendar_pkg.sv | 38 +++
 rtl/calendar_month_len.sv | 21 ++
 rtl/calendar_date_counter.sv | 137 +++++++++++++
 tb/tb_calendar_date_counter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calendar_pkg.sv
// Shared calendar constants and the Gregorian leap-year rule.
package calendar_pkg;

    localparam int unsigned DAY_W  = 5;
    localparam int unsigned MON_W  = 4;
    localparam int unsigned WDAY_W = 3;

    localparam logic [MON_W-1:0] JAN = 4'd1;
    localparam logic [MON_W-1:0] FEB = 4'd2;
    localparam logic [MON_W-1:0] MAR = 4'd3;
    localparam logic [MON_W-1:0] APR = 4'd4;
    localparam logic [MON_W-1:0] MAY = 4'd5;
    localparam logic [MON_W-1:0] JUN = 4'd6;
    localparam logic [MON_W-1:0] JUL = 4'd7;
    localparam logic [MON_W-1:0] AUG = 4'd8;
    localparam logic [MON_W-1:0] SEP = 4'd9;
    localparam logic [MON_W-1:0] OCT = 4'd10;
    localparam logic [MON_W-1:0] NOV = 4'd11;
    localparam logic [MON_W-1:0] DEC = 4'd12;

    localparam logic [WDAY_W-1:0] SUN = 3'd0;
    localparam logic [WDAY_W-1:0] MON = 3'd1;
    localparam logic [WDAY_W-1:0] TUE = 3'd2;
    localparam logic [WDAY_W-1:0] WED = 3'd3;
    localparam logic [WDAY_W-1:0] THU = 3'd4;
    localparam logic [WDAY_W-1:0] FRI = 3'd5;
    localparam logic [WDAY_W-1:0] SAT = 3'd6;

    localparam logic [1:0] SEL_DAY  = 2'd0;
    localparam logic [1:0] SEL_MON  = 2'd1;
    localparam logic [1:0] SEL_YEAR = 2'd2;
    localparam logic [1:0] SEL_WDAY = 2'd3;

    function automatic logic is_leap(input int unsigned y);
        return ((y % 400) == 0) || (((y % 100) != 0) && ((y % 4) == 0));
    endfunction

endpackage

// File: rtl/calendar_month_len.sv
// Month length lookup; out-of-range months report 31.
module calendar_month_len
    import calendar_pkg::*;
#(
    parameter int unsigned YEAR_W = 14
) (
    input  logic [MON_W-1:0]  mon,
    input  logic [YEAR_W-1:0] year,
    output logic [DAY_W-1:0]  max_day
);

    always_comb begin
        max_day = 5'd31;
        case (mon)
            APR, JUN, SEP, NOV: max_day = 5'd30;
            FEB:                max_day = is_leap(32'(year)) ? 5'd29 : 5'd28;
            default:            max_day = 5'd31;
        endcase
    end

endmodule

// File: rtl/calendar_date_counter.sv
// Day/month/year/weekday counter with front-panel adjust, self-recovery and year-wrap carry.
module calendar_date_counter
    import calendar_pkg::*;
#(
    parameter int unsigned YEAR_W     = 14,
    parameter int unsigned YEAR_MIN   = 2000,
    parameter int unsigned YEAR_MAX   = 2099,
    parameter int unsigned RESET_YEAR = 2000,
    parameter int unsigned RESET_WDAY = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_day,
    input  logic                adj_en,
    input  logic [1:0]          adj_sel,
    input  logic                adj_up,
    input  logic                adj_down,
    output logic [DAY_W-1:0]    day,
    output logic [MON_W-1:0]    mon,
    output logic [YEAR_W-1:0]   year,
    output logic [WDAY_W-1:0]   wday,
    output logic [DAY_W-1:0]    max_day,
    output logic                carry_year
);

    localparam logic [YEAR_W-1:0] Y_MIN = YEAR_W'(YEAR_MIN);
    localparam logic [YEAR_W-1:0] Y_MAX = YEAR_W'(YEAR_MAX);
    localparam logic [YEAR_W-1:0] Y_RST = YEAR_W'(RESET_YEAR);
    localparam logic [WDAY_W-1:0] W_RST = WDAY_W'(RESET_WDAY);

    logic               step_up, step_down;
    logic               mon_bad, year_bad, day_bad;
    logic [MON_W-1:0]   cand_mon;
    logic [YEAR_W-1:0]  cand_year;
    logic [DAY_W-1:0]   cand_max;
    logic [DAY_W-1:0]   day_n;
    logic [MON_W-1:0]   mon_n;
    logic [YEAR_W-1:0]  year_n;
    logic [WDAY_W-1:0]  wday_n;
    logic               carry_n;

    calendar_month_len #(.YEAR_W(YEAR_W)) u_len_cur (
        .mon     (mon),
        .year    (year),
        .max_day (max_day)
    );

    // Length of the month the adjust would land in, so day clamps in the same cycle.
    calendar_month_len #(.YEAR_W(YEAR_W)) u_len_next (
        .mon     (cand_mon),
        .year    (cand_year),
        .max_day (cand_max)
    );

    always_comb begin
        step_up   = adj_up & ~adj_down;
        step_down = adj_down & ~adj_up;
        cand_mon  = mon;
        cand_year = year;
        if (adj_sel == SEL_MON) begin
            if (step_up)        cand_mon = (mon >= DEC) ? JAN : mon + 4'd1;
            else if (step_down) cand_mon = (mon <= JAN) ? DEC : mon - 4'd1;
        end else if (adj_sel == SEL_YEAR) begin
            if (step_up)        cand_year = (year >= Y_MAX) ? Y_MIN : year + YEAR_W'(1);
            else if (step_down) cand_year = (year <= Y_MIN) ? Y_MAX : year - YEAR_W'(1);
        end
    end

    always_comb begin
        day_n    = day;
        mon_n    = mon;
        year_n   = year;
        wday_n   = wday;
        carry_n  = 1'b0;
        mon_bad  = (mon < JAN) || (mon > DEC);
        year_bad = (year < Y_MIN) || (year > Y_MAX);
        day_bad  = (day == 5'd0) || (day > max_day);
        if (mon_bad || year_bad || day_bad) begin
            if (mon_bad)  mon_n  = JAN;
            if (year_bad) year_n = Y_MIN;
            if (day_bad)  day_n  = 5'd1;
        end else if (adj_en) begin
            if (step_up || step_down) begin
                case (adj_sel)
                    SEL_DAY: begin
                        if (step_up) day_n = (day >= max_day) ? 5'd1 : day + 5'd1;
                        else         day_n = (day <= 5'd1) ? max_day : day - 5'd1;
                    end
                    SEL_MON, SEL_YEAR: begin
                        mon_n  = cand_mon;
                        year_n = cand_year;
                        if (day > cand_max) day_n = cand_max;
                    end
                    default: begin
                        if (step_up) wday_n = (wday >= SAT) ? SUN : wday + 3'd1;
                        else         wday_n = (wday == SUN) ? SAT : wday - 3'd1;
                    end
                endcase
            end
        end else if (tick_day) begin
            wday_n = (wday >= SAT) ? SUN : wday + 3'd1;
            if (day < max_day) begin
                day_n = day + 5'd1;
            end else begin
                day_n = 5'd1;
                if (mon == DEC) begin
                    mon_n = JAN;
                    if (year == Y_MAX) begin
                        year_n  = Y_MIN;
                        carry_n = 1'b1;
                    end else begin
                        year_n = year + YEAR_W'(1);
                    end
                end else begin
                    mon_n = mon + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            day        <= 5'd1;
            mon        <= JAN;
            year       <= Y_RST;
            wday       <= W_RST;
            carry_year <= 1'b0;
        end else begin
            day        <= day_n;
            mon        <= mon_n;
            year       <= year_n;
            wday       <= wday_n;
            carry_year <= carry_n;
        end
    end

endmodule

// File: tb/tb_calendar_date_counter.sv
// Randomized and directed bench for calendar_date_counter against a date-arithmetic model.
module tb_calendar_date_counter;
    import calendar_pkg::*;

    localparam int unsigned YEAR_W = 14;
    localparam int YMIN = 2000;
    localparam int YMAX = 2099;

    logic              clk = 1'b0;
    logic              rst;
    logic              tick_day, adj_en, adj_up, adj_down;
    logic [1:0]        adj_sel;
    logic [4:0]        day, max_day;
    logic [3:0]        mon;
    logic [YEAR_W-1:0] year;
    logic [2:0]        wday;
    logic              carry_year;

    logic              b_adj_en, b_up;
    logic [1:0]        b_sel;
    logic [4:0]        b_day, b_max_day;
    logic [3:0]        b_mon;
    logic [YEAR_W-1:0] b_year;
    logic [2:0]        b_wday;
    logic              b_carry;

    int n_tests = 0;
    int n_fail  = 0;
    int m_day, m_mon, m_year, m_wday, m_carry;
    int s_day, s_year, s_wday;

    always #5 clk = ~clk;

    calendar_date_counter #(
        .YEAR_W(YEAR_W), .YEAR_MIN(2000), .YEAR_MAX(2099), .RESET_YEAR(2000), .RESET_WDAY(6)
    ) dut (
        .clk(clk), .rst(rst), .tick_day(tick_day), .adj_en(adj_en), .adj_sel(adj_sel),
        .adj_up(adj_up), .adj_down(adj_down), .day(day), .mon(mon), .year(year),
        .wday(wday), .max_day(max_day), .carry_year(carry_year)
    );

    calendar_date_counter #(
        .YEAR_W(YEAR_W), .YEAR_MIN(2000), .YEAR_MAX(2199), .RESET_YEAR(2000), .RESET_WDAY(6)
    ) dut_wide (
        .clk(clk), .rst(rst), .tick_day(1'b0), .adj_en(b_adj_en), .adj_sel(b_sel),
        .adj_up(b_up), .adj_down(1'b0), .day(b_day), .mon(b_mon), .year(b_year),
        .wday(b_wday), .max_day(b_max_day), .carry_year(b_carry)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int dim(input int mo, input int y);
        bit leap;
        leap = ((y % 400) == 0) || (((y % 100) != 0) && ((y % 4) == 0));
        if (mo == 2) return leap ? 29 : 28;
        if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
        return 31;
    endfunction

    function automatic int model_field(input logic [1:0] sel);
        case (sel)
            2'd0:    return m_day;
            2'd1:    return m_mon;
            2'd2:    return m_year;
            default: return m_wday;
        endcase
    endfunction

    function automatic int dut_field(input logic [1:0] sel);
        case (sel)
            2'd0:    return int'(day);
            2'd1:    return int'(mon);
            2'd2:    return int'(year);
            default: return int'(wday);
        endcase
    endfunction

    task automatic model_reset();
        m_day = 1; m_mon = 1; m_year = 2000; m_wday = 6; m_carry = 0;
    endtask

    task automatic model_apply(input bit t, input bit en, input logic [1:0] sel,
                               input bit up, input bit dn);
        m_carry = 0;
        if (en) begin
            if (up != dn) begin
                case (sel)
                    2'd0: if (up) m_day = (m_day == dim(m_mon, m_year)) ? 1 : m_day + 1;
                          else    m_day = (m_day == 1) ? dim(m_mon, m_year) : m_day - 1;
                    2'd1: begin
                        m_mon = up ? (m_mon % 12) + 1 : ((m_mon + 10) % 12) + 1;
                        if (m_day > dim(m_mon, m_year)) m_day = dim(m_mon, m_year);
                    end
                    2'd2: begin
                        if (up) m_year = (m_year == YMAX) ? YMIN : m_year + 1;
                        else    m_year = (m_year == YMIN) ? YMAX : m_year - 1;
                        if (m_day > dim(m_mon, m_year)) m_day = dim(m_mon, m_year);
                    end
                    default: m_wday = up ? (m_wday + 1) % 7 : (m_wday + 6) % 7;
                endcase
            end
        end else if (t) begin
            m_wday = (m_wday + 1) % 7;
            if (m_day < dim(m_mon, m_year)) begin
                m_day++;
            end else begin
                m_day = 1;
                if (m_mon == 12) begin
                    m_mon = 1;
                    if (m_year == YMAX) begin
                        m_year  = YMIN;
                        m_carry = 1;
                    end else begin
                        m_year++;
                    end
                end else begin
                    m_mon++;
                end
            end
        end
    endtask

    task automatic check_all();
        check("day", day, m_day);
        check("mon", mon, m_mon);
        check("year", year, m_year);
        check("wday", wday, m_wday);
        check("carry_year", carry_year, m_carry);
        check("max_day", max_day, dim(m_mon, m_year));
    endtask

    task automatic step(input bit t, input bit en, input logic [1:0] sel,
                        input bit up, input bit dn);
        tick_day = t; adj_en = en; adj_sel = sel; adj_up = up; adj_down = dn;
        @(posedge clk);
        #1;
        model_apply(t, en, sel, up, dn);
        check_all();
    endtask

    task automatic adjust_to(input logic [1:0] sel, input int target, input string tag);
        for (int i = 0; i < 400; i++) begin
            if (model_field(sel) == target) break;
            step(1'b0, 1'b1, sel, 1'b1, 1'b0);
        end
        check(tag, dut_field(sel), target);
    endtask

    task automatic b_adjust(input logic [1:0] sel, input int n);
        for (int i = 0; i < n; i++) begin
            b_adj_en = 1'b1; b_sel = sel; b_up = 1'b1;
            @(posedge clk);
            #1;
        end
        b_adj_en = 1'b0; b_up = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        tick_day = 0; adj_en = 0; adj_sel = 2'd0; adj_up = 0; adj_down = 0;
        b_adj_en = 0; b_sel = 2'd0; b_up = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_day", day, 1);
        check("rst_mon", mon, 1);
        check("rst_year", year, 2000);
        check("rst_wday", wday, 6);
        check("rst_carry", carry_year, 0);
        rst = 1'b0;

        // 59 days from Sat 2000-01-01 lands on leap day, a Tuesday
        repeat (59) step(1'b1, 1'b0, SEL_DAY, 1'b0, 1'b0);
        check("feb29_day", day, 29);
        check("feb29_mon", mon, 2);
        check("feb29_wday", wday, 2);
        check("feb29_maxday", max_day, 29);
        step(1'b1, 1'b0, SEL_DAY, 1'b0, 1'b0);
        check("mar1_day", day, 1);
        check("mar1_mon", mon, 3);
        check("mar1_wday", wday, 3);

        // Year-range wrap with carry
        adjust_to(SEL_YEAR, 2099, "set_year_2099");
        adjust_to(SEL_MON, 12, "set_mon_12");
        adjust_to(SEL_DAY, 31, "set_day_31");
        step(1'b1, 1'b0, SEL_DAY, 1'b0, 1'b0);
        check("wrap_carry", carry_year, 1);
        check("wrap_year", year, 2000);
        check("wrap_mon", mon, 1);
        check("wrap_day", day, 1);
        step(1'b0, 1'b0, SEL_DAY, 1'b0, 1'b0);
        check("wrap_carry_drop", carry_year, 0);

        // Clamp on month and year adjust
        adjust_to(SEL_YEAR, 2024, "set_year_2024");
        adjust_to(SEL_MON, 1, "set_mon_1");
        adjust_to(SEL_DAY, 31, "set_day_31b");
        step(1'b0, 1'b1, SEL_MON, 1'b1, 1'b0);
        check("clamp_mon_day", day, 29);
        check("clamp_mon_mon", mon, 2);
        step(1'b0, 1'b1, SEL_YEAR, 1'b1, 1'b0);
        check("clamp_year_day", day, 28);
        check("clamp_year_year", year, 2025);

        // Both directions plus tick during adjust: hold, no carry
        step(1'b1, 1'b1, SEL_DAY, 1'b1, 1'b1);
        check("hold_day", day, 28);
        check("hold_wday", wday, m_wday);
        check("hold_carry", carry_year, 0);

        adjust_to(SEL_MON, 4, "set_mon_4");
        adjust_to(SEL_DAY, 1, "set_day_1");
        step(1'b0, 1'b1, SEL_DAY, 1'b0, 1'b1);
        check("april_wrap_down", day, 30);

        // Recovery from an illegal month; a tick presented meanwhile must be ignored
        s_day = m_day; s_year = m_year; s_wday = m_wday;
        force dut.mon = 4'd13;
        tick_day = 1'b1; adj_en = 1'b0;
        @(posedge clk);
        #1;
        release dut.mon;
        tick_day = 1'b0;
        @(posedge clk);
        #1;
        check("recover_mon", mon, 1);
        check("recover_day", day, s_day);
        check("recover_year", year, s_year);
        check("recover_wday", wday, s_wday);
        m_mon = 1;

        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 12)
                step(1'($urandom), 1'b1, 2'($urandom), 1'($urandom), 1'($urandom));
            else
                step(r < 80, 1'b0, 2'($urandom), 1'($urandom), 1'($urandom));
        end

        // Asynchronous reset in the middle of activity
        tick_day = 1'b1; adj_en = 1'b1; adj_sel = SEL_YEAR; adj_up = 1'b1; adj_down = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("midrst_day", day, 1);
        check("midrst_mon", mon, 1);
        check("midrst_year", year, 2000);
        check("midrst_wday", wday, 6);
        check("midrst_carry", carry_year, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        step(1'b1, 1'b0, SEL_DAY, 1'b0, 1'b0);
        check("post_rst_day", day, 2);
        check("post_rst_wday", wday, 0);

        // Century leap rule on the wide-range instance
        tick_day = 0; adj_en = 0; adj_up = 0; adj_down = 0;
        b_adjust(SEL_MON, 1);
        check("leap2000_mon", b_mon, 2);
        check("leap2000_maxday", b_max_day, 29);
        b_adjust(SEL_YEAR, 24);
        check("leap2024_maxday", b_max_day, 29);
        b_adjust(SEL_YEAR, 76);
        check("leap2100_year", b_year, 2100);
        check("leap2100_maxday", b_max_day, 28);
        check("wide_carry", b_carry, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
